// File: rtl/digpot_step_ctrl.sv
// digpot_step_ctrl: drives the shared INC and U/D lines plus a per-chip CS of
// up to NUM_CH three-wire digital potentiometers. One request produces a CS-framed
// burst of `num` INC pulses. At the end the chip either stores the wiper to NV
// memory or discards it, depending on the INC level when CS rises.
// Optional wiper tracking is built when DIGPOT_POS_TRACK_EN is defined.
module digpot_step_ctrl #(
   parameter int NUM_CH  = 2,
   parameter int STEP_W  = 7,
   parameter int HALF    = 4,
   parameter int T_SU    = 2,
   parameter int POS_MAX = 99
) (
   input  logic                                            clk_in,
   input  logic                                            reset,
   input  logic                                            start,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  ch_sel,
   input  logic [STEP_W-1:0]                               num,
   input  logic                                            up,
   input  logic                                            store,
   output logic                                            busy,
   output logic                                            done,
   output logic                                            inc_n,
   output logic                                            ud,
   output logic [NUM_CH-1:0]                               cs_n,
   output logic [STEP_W-1:0]                               pos
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int TMR_MAX = (T_SU > HALF) ? T_SU : HALF;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   if (HALF < 1 || T_SU < 1 || NUM_CH < 1 || POS_MAX < 0 || POS_MAX >= (1 << STEP_W)) begin : g_bad_param
      $error("digpot_step_ctrl: illegal parameter set");
   end

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      ENDW,
      CSUP
   } state_t;

   state_t              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [STEP_W-1:0]   num_q, num_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                up_q, up_d;
   logic                store_q, store_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                inc_n_q, inc_n_d;
   logic [NUM_CH-1:0]   cs_n_q, cs_n_d;
   logic                start_ok;
   logic                tmr_last;

   // Requests are only honoured while idle and for an existing chip.
   always_comb begin
      start_ok = (state_q == IDLE) && start && (32'(ch_sel) < NUM_CH);
   end

   // Flags the final cycle of the current timed phase.
   always_comb begin
      tmr_last = 1'b0;
      case (state_q)
         SETUP:          tmr_last = (tmr_q == TMR_W'(T_SU - 1));
         LOW, HIGH, ENDW: tmr_last = (tmr_q == TMR_W'(HALF - 1));
         CSUP:           tmr_last = 1'b1;
         default:        tmr_last = 1'b0;
      endcase
   end

   // Next-state, request latching and registered-output decode.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      step_d  = step_q;
      num_d   = num_q;
      ch_d    = ch_q;
      up_d    = up_q;
      store_d = store_q;

      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (start_ok) begin
               state_d = SETUP;
               step_d  = '0;
               num_d   = num;
               ch_d    = ch_sel;
               up_d    = up;
               store_d = store;
            end
         end
         SETUP: begin
            if (tmr_last) begin
               tmr_d = '0;
               // A zero-step request still runs the end-wait phase so the
               // busy window length follows one formula for every num.
               state_d = (num_q != '0) ? LOW : ENDW;
            end
         end
         LOW: begin
            if (tmr_last) begin
               tmr_d   = '0;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (tmr_last) begin
               tmr_d   = '0;
               step_d  = step_q + 1'b1;
               state_d = (step_d < num_q) ? LOW : ENDW;
            end
         end
         ENDW: begin
            if (tmr_last) begin
               tmr_d   = '0;
               state_d = CSUP;
            end
         end
         CSUP: begin
            tmr_d   = '0;
            state_d = IDLE;
         end
         default: begin
            tmr_d   = '0;
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the upcoming state so they appear registered;
      // CS stays low through CSUP and rises on return to IDLE, so the chip
      // sees INC = store at the CS rising edge.
      busy_d = (state_d != IDLE);
      done_d = (state_q == CSUP);

      case (state_d)
         LOW:        inc_n_d = 1'b0;
         ENDW, CSUP: inc_n_d = store_d;
         default:    inc_n_d = 1'b1;
      endcase

      cs_n_d = '1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (busy_d && (32'(ch_d) == i)) begin
            cs_n_d[i] = 1'b0;
         end
      end
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         step_q  <= '0;
         num_q   <= '0;
         ch_q    <= '0;
         up_q    <= 1'b0;
         store_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         inc_n_q <= 1'b1;
         cs_n_q  <= '1;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         step_q  <= step_d;
         num_q   <= num_d;
         ch_q    <= ch_d;
         up_q    <= up_d;
         store_q <= store_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         inc_n_q <= inc_n_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign inc_n = inc_n_q;
   assign ud    = up_q;
   assign cs_n  = cs_n_q;

`ifdef DIGPOT_POS_TRACK_EN
   localparam logic [STEP_W-1:0] POS_TOP = STEP_W'(POS_MAX);

   logic [STEP_W-1:0] pos_q [NUM_CH];
   logic [STEP_W-1:0] pos_d [NUM_CH];
   logic              low_exit;

   // One wiper step is taken by the chip at the end of each INC low phase.
   always_comb begin
      low_exit = (state_q == LOW) && tmr_last;
      pos_d    = pos_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (low_exit && (32'(ch_q) == i)) begin
            if (up_q) begin
               if (pos_q[i] < POS_TOP) begin
                  pos_d[i] = pos_q[i] + 1'b1;
               end
            end else if (pos_q[i] != '0) begin
               pos_d[i] = pos_q[i] - 1'b1;
            end
         end
      end
   end

   // Per-chip tracked wiper registers.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            pos_q[i] <= '0;
         end
      end else begin
         pos_q <= pos_d;
      end
   end

   // Wiper of the currently selected chip; unknown chips read as zero.
   always_comb begin
      pos = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (32'(ch_sel) == i) begin
            pos = pos_q[i];
         end
      end
   end
`else
   assign pos = '0;
`endif

endmodule

// File: tb/tb_digpot_step_ctrl.sv
// Bench for digpot_step_ctrl: directed and random transactions checked cycle by
// cycle against an arithmetic model of the INC/CS waveform and wiper position.
// Define DIGPOT_POS_TRACK_EN for both files to exercise wiper tracking.
module tb_digpot_step_ctrl;

   localparam int NUM_CH  = 2;
   localparam int STEP_W  = 7;
   localparam int HALF    = 4;
   localparam int T_SU    = 2;
   localparam int POS_MAX = 99;

   logic              clk_in = 1'b0;
   logic              reset;
   logic              start;
   logic [0:0]        ch_sel;
   logic [STEP_W-1:0] num;
   logic              up;
   logic              store;
   logic              busy;
   logic              done;
   logic              inc_n;
   logic              ud;
   logic [NUM_CH-1:0] cs_n;
   logic [STEP_W-1:0] pos;

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   int          pos_m [NUM_CH];

   digpot_step_ctrl #(
      .NUM_CH (NUM_CH),
      .STEP_W (STEP_W),
      .HALF   (HALF),
      .T_SU   (T_SU),
      .POS_MAX(POS_MAX)
   ) dut (
      .clk_in(clk_in),
      .reset (reset),
      .start (start),
      .ch_sel(ch_sel),
      .num   (num),
      .up    (up),
      .store (store),
      .busy  (busy),
      .done  (done),
      .inc_n (inc_n),
      .ud    (ud),
      .cs_n  (cs_n),
      .pos   (pos)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected INC level k cycles into the busy window.
   function automatic logic exp_inc(input int k, input int n, input logic s);
      int t;
      if (k < T_SU) return 1'b1;
      t = k - T_SU;
      if (t < 2 * HALF * n) return ((t / HALF) % 2 == 0) ? 1'b0 : 1'b1;
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk_in);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 reset = 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos_m[i] = 0;
   endtask

   task automatic chk_idle_reset_state(input string tag);
      chk({tag, "_busy"},  busy,  0);
      chk({tag, "_done"},  done,  0);
      chk({tag, "_inc_n"}, inc_n, 1);
      chk({tag, "_ud"},    ud,    0);
      chk({tag, "_cs_n"},  cs_n,  {NUM_CH{1'b1}});
      chk({tag, "_pos"},   pos,   0);
   endtask

   // One full transaction; inj >= 0 fires a conflicting start at that busy cycle.
   task automatic run_txn(input int ch, input int n, input logic u, input logic s, input int inj);
      int                len;
      logic [NUM_CH-1:0] cs_e;
      len  = T_SU + 2 * HALF * n + HALF + 1;
      cs_e = '1;
      cs_e[ch] = 1'b0;
      @(negedge clk_in);
      start  = 1'b1;
      ch_sel = 1'(ch);
      num    = STEP_W'(n);
      up     = u;
      store  = s;
      @(posedge clk_in);
      #1 start = 1'b0;
      for (int k = 0; k < len; k++) begin
         @(negedge clk_in);
         chk("busy_win",  busy,  1);
         chk("done_win",  done,  0);
         chk("cs_n_win",  cs_n,  cs_e);
         chk("ud_win",    ud,    u);
         chk("inc_n_win", inc_n, exp_inc(k, n, s));
         if (k == inj) begin
            start  = 1'b1;
            ch_sel = 1'(1 - ch);
            num    = STEP_W'(n + 2);
            up     = ~u;
            store  = ~s;
         end else if (k == inj + 1) begin
            start  = 1'b0;
            ch_sel = 1'(ch);
            num    = STEP_W'(n);
            up     = u;
            store  = s;
         end
      end
      @(negedge clk_in);
      start  = 1'b0;
      ch_sel = 1'(ch);
`ifdef DIGPOT_POS_TRACK_EN
      if (u) pos_m[ch] = (pos_m[ch] + n > POS_MAX) ? POS_MAX : pos_m[ch] + n;
      else   pos_m[ch] = (n > pos_m[ch]) ? 0 : pos_m[ch] - n;
`endif
      #1;
      chk("busy_end",  busy,  0);
      chk("done_end",  done,  1);
      chk("inc_n_end", inc_n, 1);
      chk("cs_n_end",  cs_n,  {NUM_CH{1'b1}});
      chk("pos_end",   pos,   pos_m[ch]);
      @(negedge clk_in);
      chk("done_once", done, 0);
      chk("busy_idle", busy, 0);
   endtask

   initial begin
      int ch, n, inj;
      logic u, s;
      reset  = 1'b1;
      start  = 1'b0;
      ch_sel = '0;
      num    = '0;
      up     = 1'b0;
      store  = 1'b0;
      do_reset();
      @(negedge clk_in);
      chk_idle_reset_state("rst");

      // Three increments on chip 1 with store.
      run_txn(1, 3, 1'b1, 1'b1, -1);
      // Zero-step framing without store.
      run_txn(0, 0, 1'b0, 1'b0, -1);
      // Conflicting request during busy is ignored.
      run_txn(0, 4, 1'b0, 1'b1, 5);

      // Reset in the second LOW phase, with start held to show reset wins.
      @(negedge clk_in);
      start  = 1'b1;
      ch_sel = 1'b0;
      num    = STEP_W'(3);
      up     = 1'b1;
      store  = 1'b1;
      @(posedge clk_in);
      #1 start = 1'b0;
      repeat (T_SU + 2 * HALF + 2) @(negedge clk_in);
      chk("mid_low", inc_n, 0);
      reset  = 1'b1;
      start  = 1'b1;
      ch_sel = 1'b1;
      @(posedge clk_in);
      #1 reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos_m[i] = 0;
      @(negedge clk_in);
      chk_idle_reset_state("mid_rst");
      repeat (3) begin
         @(negedge clk_in);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_done", done, 0);
      end
      run_txn(1, 2, 1'b1, 1'b0, -1);

      // Random transactions.
      for (int r = 0; r < 10; r++) begin
         ch  = int'($urandom_range(0, NUM_CH - 1));
         n   = int'($urandom_range(0, 9));
         u   = 1'($urandom);
         s   = 1'($urandom);
         inj = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, T_SU + HALF - 3));
         run_txn(ch, n, u, s, inj);
      end

`ifdef DIGPOT_POS_TRACK_EN
      do_reset();
      run_txn(0, 120, 1'b1, 1'b1, -1);
      chk("pos_sat_top", pos, 99);
      run_txn(0, 5, 1'b0, 1'b1, -1);
      chk("pos_after_dn", pos, 94);
      ch_sel = 1'b1;
      #1 chk("pos_other_ch", pos, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
